// File: rtl/snn_ctrl_pkg.sv
// Shared types and constants for the SNN inference controller.
package snn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EVAL,
    REQ,
    ACKLO,
    TICK,
    WAIT_DONE,
    DONE
  } ctrl_state_e;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_REQ,
    HS_ACKLO
  } hs_state_e;

  localparam int unsigned TO_CNT_W = 32;

  // Rate-code threshold increment per timestep: 2^pixel_bits / timesteps.
  function automatic int unsigned thr_step(input int unsigned pixel_bits,
                                           input int unsigned timesteps);
    return (32'd1 << pixel_bits) / timesteps;
  endfunction

endpackage

// File: rtl/snn_inference_controller_aer_tx.sv
// Four-phase AER sender: raises req with a latched address, drops it on ack, reports done once ack falls.
module aer_tx_handshake
  import snn_ctrl_pkg::*;
#(
  parameter int unsigned AW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [AW-1:0] i_addr,
  input  logic          i_ack,
  output logic          o_req,
  output logic [AW-1:0] o_addr,
  output logic          o_busy,
  output logic          o_done
);

  hs_state_e     r_state;
  logic          r_req;
  logic [AW-1:0] r_addr;
  logic          r_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= HS_IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        HS_IDLE: begin
          if (i_start) begin
            r_req   <= 1'b1;
            r_addr  <= i_addr;
            r_state <= HS_REQ;
          end
        end
        HS_REQ: begin
          if (i_ack) begin
            r_req   <= 1'b0;
            r_state <= HS_ACKLO;
          end
        end
        HS_ACKLO: begin
          if (!i_ack) begin
            r_done  <= 1'b1;
            r_state <= HS_IDLE;
          end
        end
        default: r_state <= HS_IDLE;
      endcase
    end
  end

  assign o_req  = r_req;
  assign o_addr = r_addr;
  assign o_busy = (r_state != HS_IDLE);
  assign o_done = r_done;

endmodule

// File: rtl/snn_inference_controller.sv
// Rate-coding SNN inference sequencer: scans pixels per timestep, emits AER spikes, captures the result.
// Optional watchdog in WAIT_DONE enabled by defining INF_TIMEOUT_EN.
module snn_inference_controller
  import snn_ctrl_pkg::*;
#(
  parameter int unsigned N              = 256,
  parameter int unsigned M              = 8,
  parameter int unsigned IMAGE_SIZE     = 256,
  parameter int unsigned PIXEL_BITS     = 8,
  parameter int unsigned TIMESTEPS      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          NEW_IMAGE,
  output logic [$clog2(IMAGE_SIZE)-1:0] PIX_ADDR,
  input  logic [PIXEL_BITS-1:0]         PIX_DATA,
  output logic [M-1:0]                  AER_ADDR,
  output logic                          AER_REQ,
  input  logic                          AER_ACK,
  output logic                          SNN_TICK,
  input  logic                          SNN_DONE,
  input  logic [M-1:0]                  INFERED_DIGIT,
  output logic [M-1:0]                  RESULT_DIGIT,
  output logic                          RESULT_VALID,
  output logic                          BUSY,
  output logic                          TIMEOUT_ERR
);

  localparam int unsigned     PA_W      = $clog2(IMAGE_SIZE);
  localparam int unsigned     ST_W      = (TIMESTEPS > 1) ? $clog2(TIMESTEPS) : 1;
  localparam int unsigned     THR_STEP  = thr_step(PIXEL_BITS, TIMESTEPS);
  localparam logic [PA_W-1:0] LAST_PIX  = PA_W'(IMAGE_SIZE - 1);
  localparam logic [ST_W-1:0] LAST_STEP = ST_W'(TIMESTEPS - 1);

  ctrl_state_e     r_state;
  logic            r_new_d;
  logic [PA_W-1:0] r_pix_cnt;
  logic [ST_W-1:0] r_step;
  logic            r_tick;
  logic            r_busy;
  logic            r_valid;
  logic [M-1:0]    r_result;
`ifdef INF_TIMEOUT_EN
  logic [TO_CNT_W-1:0] r_to_cnt;
  logic                r_to_err;
`endif

  logic [PIXEL_BITS:0] w_thr;
  logic                w_spike;
  logic                w_last_pix;
  logic                w_hs_start;
  logic                w_hs_busy;
  logic                w_hs_done;
  logic [M-1:0]        w_aer_idx;

  // One extra bit keeps t*step from wrapping against full-scale pixel values.
  assign w_thr      = (PIXEL_BITS+1)'(32'(r_step) * THR_STEP);
  assign w_spike    = {1'b0, PIX_DATA} > w_thr;
  assign w_last_pix = (r_pix_cnt == LAST_PIX);
  assign w_hs_start = (r_state == EVAL) && w_spike && !w_hs_busy;
  assign w_aer_idx  = M'(r_pix_cnt);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state   <= IDLE;
      r_new_d   <= 1'b0;
      r_pix_cnt <= '0;
      r_step    <= '0;
      r_tick    <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_result  <= '0;
`ifdef INF_TIMEOUT_EN
      r_to_cnt  <= '0;
      r_to_err  <= 1'b0;
`endif
    end else begin
      r_new_d <= NEW_IMAGE;
      r_tick  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (NEW_IMAGE && !r_new_d) begin
            r_pix_cnt <= '0;
            r_step    <= '0;
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_busy    <= 1'b1;
            r_state   <= FETCH;
`ifdef INF_TIMEOUT_EN
            r_to_cnt  <= '0;
            r_to_err  <= 1'b0;
`endif
          end
        end
        FETCH: r_state <= EVAL;
        EVAL: begin
          if (w_spike) begin
            if (!w_hs_busy) r_state <= REQ;
          end else if (w_last_pix) begin
            r_tick  <= 1'b1;
            r_state <= TICK;
          end else begin
            r_pix_cnt <= r_pix_cnt + PA_W'(1);
            r_state   <= FETCH;
          end
        end
        REQ: begin
          if (AER_ACK) r_state <= ACKLO;
        end
        ACKLO: begin
          if (w_hs_done) begin
            if (w_last_pix) begin
              r_tick  <= 1'b1;
              r_state <= TICK;
            end else begin
              r_pix_cnt <= r_pix_cnt + PA_W'(1);
              r_state   <= FETCH;
            end
          end
        end
        TICK: begin
          r_pix_cnt <= '0;
          r_step    <= r_step + ST_W'(1);
          r_state   <= (r_step == LAST_STEP) ? WAIT_DONE : FETCH;
        end
        WAIT_DONE: begin
          if (SNN_DONE) begin
            r_result <= INFERED_DIGIT;
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= DONE;
          end
`ifdef INF_TIMEOUT_EN
          else if (r_to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_result <= '1;
            r_valid  <= 1'b1;
            r_to_err <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= DONE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_CNT_W'(1);
          end
`endif
        end
        DONE: begin
          if (!NEW_IMAGE) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  aer_tx_handshake #(
    .AW (M)
  ) u_aer_tx (
    .i_clk   (ACLK),
    .i_rst_n (ARESETN),
    .i_start (w_hs_start),
    .i_addr  (w_aer_idx),
    .i_ack   (AER_ACK),
    .o_req   (AER_REQ),
    .o_addr  (AER_ADDR),
    .o_busy  (w_hs_busy),
    .o_done  (w_hs_done)
  );

  assign PIX_ADDR     = r_pix_cnt;
  assign SNN_TICK     = r_tick;
  assign RESULT_DIGIT = r_result;
  assign RESULT_VALID = r_valid;
  assign BUSY         = r_busy;
`ifdef INF_TIMEOUT_EN
  assign TIMEOUT_ERR  = r_to_err;
`else
  assign TIMEOUT_ERR  = 1'b0;
`endif

endmodule

// File: tb/tb_snn_inference_controller.sv
// Scoreboard bench for snn_inference_controller: directed images, expected AER events and results queued.
module tb_snn_inference_controller;

  localparam int unsigned IMG = 256;
`ifdef INF_TIMEOUT_EN
  localparam int unsigned TO_C = 100;
`else
  localparam int unsigned TO_C = 65535;
`endif

  logic       ACLK;
  logic       ARESETN;
  logic       NEW_IMAGE;
  logic [7:0] PIX_ADDR;
  logic [7:0] PIX_DATA;
  logic [7:0] AER_ADDR;
  logic       AER_REQ;
  logic       AER_ACK;
  logic       SNN_TICK;
  logic       SNN_DONE;
  logic [7:0] INFERED_DIGIT;
  logic [7:0] RESULT_DIGIT;
  logic       RESULT_VALID;
  logic       BUSY;
  logic       TIMEOUT_ERR;

  snn_inference_controller #(
    .N              (256),
    .M              (8),
    .IMAGE_SIZE     (IMG),
    .PIXEL_BITS     (8),
    .TIMESTEPS      (16),
    .TIMEOUT_CYCLES (TO_C)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .NEW_IMAGE     (NEW_IMAGE),
    .PIX_ADDR      (PIX_ADDR),
    .PIX_DATA      (PIX_DATA),
    .AER_ADDR      (AER_ADDR),
    .AER_REQ       (AER_REQ),
    .AER_ACK       (AER_ACK),
    .SNN_TICK      (SNN_TICK),
    .SNN_DONE      (SNN_DONE),
    .INFERED_DIGIT (INFERED_DIGIT),
    .RESULT_DIGIT  (RESULT_DIGIT),
    .RESULT_VALID  (RESULT_VALID),
    .BUSY          (BUSY),
    .TIMEOUT_ERR   (TIMEOUT_ERR)
  );

  typedef struct {int step; int addr;} aer_exp_t;
  typedef struct {int digit; int err;} res_exp_t;

  aer_exp_t   aer_q[$];
  res_exp_t   res_q[$];
  int         total = 0;
  int         bad = 0;
  int         tick_total = 0;
  int         tick_base = 0;
  int         ack_delay = 0;
  int         min_hold = 0;
  logic [7:0] mem [IMG];

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel memory with one cycle read latency.
  initial begin
    logic [7:0] pa;
    PIX_DATA = '0;
    forever begin
      @(negedge ACLK);
      pa = PIX_ADDR;
      @(posedge ACLK);
      #1 PIX_DATA = mem[pa];
    end
  end

  // AER receiver: acks after ack_delay cycles, releases ack after req drops.
  initial begin
    int ack_wait;
    AER_ACK  = 1'b0;
    ack_wait = 0;
    forever begin
      @(posedge ACLK);
      #1;
      if (!ARESETN) begin
        AER_ACK  = 1'b0;
        ack_wait = 0;
      end else if (AER_REQ && !AER_ACK) begin
        if (ack_wait >= ack_delay) begin
          AER_ACK  = 1'b1;
          ack_wait = 0;
        end else begin
          ack_wait++;
        end
      end else if (!AER_REQ && AER_ACK) begin
        AER_ACK = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event or a result.
  initial begin
    logic       prev_req;
    logic       prev_valid;
    int         hold;
    logic [7:0] lat_addr;
    bit         unstable;
    aer_exp_t   e;
    res_exp_t   r;
    prev_req   = 1'b0;
    prev_valid = 1'b0;
    hold       = 0;
    lat_addr   = '0;
    unstable   = 1'b0;
    forever begin
      @(negedge ACLK);
      if (SNN_TICK) tick_total++;
      if (AER_REQ && !prev_req) begin
        hold     = 1;
        lat_addr = AER_ADDR;
        unstable = 1'b0;
        chk("aer_event_expected", aer_q.size() > 0, 1);
        if (aer_q.size() > 0) begin
          e = aer_q.pop_front();
          chk("aer_addr", AER_ADDR, e.addr);
          chk("aer_step", tick_total - tick_base, e.step);
        end
      end else if (AER_REQ) begin
        hold++;
        if (AER_ADDR != lat_addr) unstable = 1'b1;
      end else if (prev_req && ARESETN) begin
        chk("aer_req_hold_min", hold >= min_hold, 1);
        chk("aer_addr_stable", unstable, 0);
      end
      if (RESULT_VALID && !prev_valid) begin
        chk("result_expected", res_q.size() > 0, 1);
        if (res_q.size() > 0) begin
          r = res_q.pop_front();
          chk("result_digit", RESULT_DIGIT, r.digit);
          chk("timeout_err", TIMEOUT_ERR, r.err);
        end
      end
      prev_req   = AER_REQ;
      prev_valid = RESULT_VALID;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < IMG; i++) mem[i] = 8'd0;
  endtask

  task automatic run_image(input int digit, input bit send_done, input bit toggle_mid,
                           output int lat);
    int n;
    @(negedge ACLK);
    tick_base = tick_total;
    NEW_IMAGE = 1'b1;
    @(negedge ACLK);
    chk("start_busy", BUSY, 1);
    chk("start_valid_clear", RESULT_VALID, 0);
    chk("start_pix_addr", PIX_ADDR, 0);
    repeat (20) @(negedge ACLK);
    SNN_DONE      = 1'b1;
    INFERED_DIGIT = 8'(~digit);
    @(negedge ACLK);
    SNN_DONE      = 1'b0;
    INFERED_DIGIT = '0;
    if (toggle_mid) begin
      NEW_IMAGE = 1'b0;
      repeat (3) @(negedge ACLK);
      NEW_IMAGE = 1'b1;
    end
    n = 0;
    while ((tick_total - tick_base) < 16 && n < 40000) begin
      @(negedge ACLK);
      n++;
    end
    chk("ticks_before_done", tick_total - tick_base, 16);
    chk("busy_in_wait_done", BUSY, 1);
    lat = 0;
    if (send_done) begin
      repeat (3) @(negedge ACLK);
      SNN_DONE      = 1'b1;
      INFERED_DIGIT = 8'(digit);
      @(negedge ACLK);
      SNN_DONE      = 1'b0;
      INFERED_DIGIT = '0;
    end
    while (!RESULT_VALID && lat < 1000) begin
      @(negedge ACLK);
      lat++;
    end
    chk("result_valid_seen", RESULT_VALID, 1);
    repeat (5) @(negedge ACLK);
    chk("tick_total", tick_total - tick_base, 16);
    chk("done_busy", BUSY, 0);
  endtask

  task automatic release_image();
    repeat (20) @(negedge ACLK);
    chk("no_restart_while_high", BUSY, 0);
    chk("valid_persist_high", RESULT_VALID, 1);
    NEW_IMAGE = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("valid_persist_idle", RESULT_VALID, 1);
    chk("idle_busy", BUSY, 0);
  endtask

  initial begin
    int lat;
    int n;
    ARESETN       = 1'b0;
    NEW_IMAGE     = 1'b0;
    SNN_DONE      = 1'b0;
    INFERED_DIGIT = '0;
    clear_mem();
    repeat (3) @(negedge ACLK);
    chk("rst_aer_req", AER_REQ, 0);
    chk("rst_aer_addr", AER_ADDR, 0);
    chk("rst_pix_addr", PIX_ADDR, 0);
    chk("rst_tick", SNN_TICK, 0);
    chk("rst_result_digit", RESULT_DIGIT, 0);
    chk("rst_result_valid", RESULT_VALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_timeout_err", TIMEOUT_ERR, 0);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);

    // Blank image: no spikes, result 7.
    res_q.push_back('{digit: 7, err: 0});
    run_image(7, 1'b1, 1'b0, lat);
    release_image();

    // Pixel 5 full scale: one event per step; pixel 9 = 17: steps 0 and 1 only.
    mem[5] = 8'd255;
    mem[9] = 8'd17;
    for (int t = 0; t < 16; t++) begin
      aer_q.push_back('{step: t, addr: 5});
      if (t < 2) aer_q.push_back('{step: t, addr: 9});
    end
    res_q.push_back('{digit: 2, err: 0});
    run_image(2, 1'b1, 1'b0, lat);
    chk("aer_all_consumed_t2", aer_q.size(), 0);
    release_image();

    // Slow receiver: 10 cycle ack delay; pixel 200 = 128 spikes in steps 0..7.
    clear_mem();
    mem[5]    = 8'd255;
    mem[200]  = 8'd128;
    ack_delay = 10;
    min_hold  = 10;
    for (int t = 0; t < 16; t++) begin
      aer_q.push_back('{step: t, addr: 5});
      if (t < 8) aer_q.push_back('{step: t, addr: 200});
    end
    res_q.push_back('{digit: 4, err: 0});
    run_image(4, 1'b1, 1'b0, lat);
    chk("aer_all_consumed_t3", aer_q.size(), 0);
    release_image();
    ack_delay = 0;
    min_hold  = 0;

    // Reset while a request is outstanding in step 3.
    clear_mem();
    mem[5] = 8'd255;
    for (int t = 0; t < 4; t++) aer_q.push_back('{step: t, addr: 5});
    @(negedge ACLK);
    tick_base = tick_total;
    NEW_IMAGE = 1'b1;
    n = 0;
    while ((tick_total - tick_base) < 3 && n < 20000) begin
      @(negedge ACLK);
      n++;
    end
    chk("reach_step3", tick_total - tick_base, 3);
    ack_delay = 1000;
    n = 0;
    while (!AER_REQ && n < 2000) begin
      @(negedge ACLK);
      n++;
    end
    chk("req_in_step3", AER_REQ, 1);
    repeat (3) @(negedge ACLK);
    #2;
    ARESETN   = 1'b0;
    NEW_IMAGE = 1'b0;
    #1;
    chk("midrst_aer_req", AER_REQ, 0);
    chk("midrst_busy", BUSY, 0);
    chk("midrst_pix_addr", PIX_ADDR, 0);
    chk("midrst_aer_addr", AER_ADDR, 0);
    repeat (3) @(negedge ACLK);
    ack_delay = 0;
    chk("aer_consumed_before_rst", aer_q.size(), 0);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    chk("post_rst_busy", BUSY, 0);
    for (int t = 0; t < 16; t++) aer_q.push_back('{step: t, addr: 5});
    res_q.push_back('{digit: 9, err: 0});
    run_image(9, 1'b1, 1'b0, lat);
    chk("aer_all_consumed_t4", aer_q.size(), 0);
    release_image();

    // NEW_IMAGE re-toggled while busy must not disturb the run.
    clear_mem();
    res_q.push_back('{digit: 3, err: 0});
    run_image(3, 1'b1, 1'b1, lat);
    release_image();

`ifdef INF_TIMEOUT_EN
    // Watchdog: SNN_DONE never arrives.
    res_q.push_back('{digit: 255, err: 1});
    run_image(0, 1'b0, 1'b0, lat);
    chk("timeout_latency_ok", (lat >= 97 && lat <= 103), 1);
    release_image();
    @(negedge ACLK);
    NEW_IMAGE = 1'b1;
    @(negedge ACLK);
    chk("timeout_err_cleared", TIMEOUT_ERR, 0);
    chk("restart_busy", BUSY, 1);
`endif

    repeat (5) @(negedge ACLK);
    chk("aer_queue_empty", aer_q.size(), 0);
    chk("result_queue_empty", res_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached total=%0d", total);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule

// File: doc/snn_inference_controller.md
SNN_INFERENCE_CONTROLLER -- requirements
Module: snn_inference_controller

Interface
REQ-001 SHALL have parameters: N, default 256, max neurons; M, default 8, log2(N); IMAGE_SIZE, default 256, pixels per image; PIXEL_BITS, default 8, pixel width; TIMESTEPS, default 16, encoding steps (power of 2); TIMEOUT_CYCLES, default 65535, watchdog limit.
REQ-002 SHALL have ports, one per line:
 ACLK  in  1  single clock, rising edge;
 ARESETN  in  1  asynchronous active-low reset;
 NEW_IMAGE  in  1  level, image loaded;
 PIX_ADDR  out  $clog2(IMAGE_SIZE)  pixel read address;
 PIX_DATA  in  PIXEL_BITS  pixel value, valid 1 cycle after PIX_ADDR;
 AER_ADDR  out  M  spike neuron index;
 AER_REQ  out  1  4-phase request;
 AER_ACK  in  1  4-phase acknowledge;
 SNN_TICK  out  1  one-cycle timestep-end pulse;
 SNN_DONE  in  1  SNN classification complete;
 INFERED_DIGIT  in  M  SNN result;
 RESULT_DIGIT  out  M  captured result;
 RESULT_VALID  out  1  result held valid;
 BUSY  out  1  inference in progress;
 TIMEOUT_ERR  out  1  watchdog expired (macro only).

Function
REQ-003 SHALL use FSM states IDLE, FETCH, EVAL, REQ, ACKLO, TICK, WAIT_DONE, DONE.
REQ-004 SHALL leave IDLE for FETCH only on a NEW_IMAGE rising edge (registered prior value); clear RESULT_VALID and step/pixel counters on start.
REQ-005 SHALL drive PIX_ADDR = pixel counter in FETCH; EVAL samples PIX_DATA one cycle later.
REQ-006 SHALL spike pixel i at step t iff PIX_DATA > t*(2^PIXEL_BITS/TIMESTEPS), unsigned, comparison at PIXEL_BITS+1 bits; value v yields ceil(v*TIMESTEPS/2^PIXEL_BITS) spikes total.
REQ-007 SHALL on spike go EVAL->REQ: AER_ADDR = i (zero-extended/truncated to M), AER_REQ=1, held until AER_ACK=1; then AER_REQ=0 in ACKLO until AER_ACK=0; AER_ADDR stable while AER_REQ=1.
REQ-008 SHALL on no spike advance pixel counter directly (EVAL->FETCH); no AER activity.
REQ-009 SHALL after pixel IMAGE_SIZE-1 enter TICK, assert SNN_TICK one cycle, wrap pixel counter to 0, increment step; step TIMESTEPS-1 -> WAIT_DONE else FETCH.
REQ-010 SHALL in WAIT_DONE capture INFERED_DIGIT into RESULT_DIGIT on first cycle SNN_DONE=1, set RESULT_VALID, go DONE.
REQ-011 SHALL hold DONE until NEW_IMAGE=0, then IDLE; RESULT_VALID/RESULT_DIGIT persist until next start.
REQ-012 SHALL ignore NEW_IMAGE falling or re-rising while BUSY; SNN_DONE outside WAIT_DONE ignored.
REQ-013 SHALL assert BUSY in every state except IDLE and DONE.

Reset
REQ-014 SHALL on ARESETN=0, asynchronously, force IDLE; outputs AER_REQ=0, AER_ADDR=0, PIX_ADDR=0, SNN_TICK=0, RESULT_DIGIT=0, RESULT_VALID=0, BUSY=0, TIMEOUT_ERR=0; counters and edge register 0.
REQ-015 SHALL abandon mid-handshake on reset (AER_REQ dropped without waiting for ACK low).

Configuration
REQ-016 SHALL with INF_TIMEOUT_EN defined count cycles in WAIT_DONE; at TIMEOUT_CYCLES without SNN_DONE go DONE, RESULT_DIGIT all-ones, RESULT_VALID=1, TIMEOUT_ERR=1 (cleared on next start).
REQ-017 SHALL without INF_TIMEOUT_EN wait indefinitely in WAIT_DONE; TIMEOUT_ERR tied 0; no counter logic.

Structure
REQ-018 SHALL place FSM state enum, threshold step constant function, and timeout counter width in package snn_ctrl_pkg.
REQ-019 SHALL implement the 4-phase sender (REQ/ACKLO) as sub-module aer_tx_handshake with start/addr in, busy/done out.

Verification
REQ-020 All pixels 0, NEW_IMAGE rise, SNN_DONE after 16 ticks with INFERED_DIGIT=7 -> zero AER_REQ, exactly 16 SNN_TICK pulses, RESULT_DIGIT=7, RESULT_VALID=1.
REQ-021 Pixel 5=255, others 0 -> exactly 16 AER events all AER_ADDR=5, one per step; pixel 9=17 -> 2 events (steps 0,1).
REQ-022 AER_ACK delayed 10 cycles on each event -> AER_REQ held 10+ cycles, AER_ADDR stable, no event lost or duplicated.
REQ-023 ARESETN low while AER_REQ=1 mid step 3 -> immediate AER_REQ=0, BUSY=0; next NEW_IMAGE rise restarts at step 0 pixel 0.
REQ-024 NEW_IMAGE held high after DONE, then toggled 1->0->1 -> second inference starts only after the 0->1 edge; RESULT_VALID cleared at start.
REQ-025 INF_TIMEOUT_EN, TIMEOUT_CYCLES=100, SNN_DONE never -> DONE after 100 cycles, RESULT_DIGIT=8'hFF, TIMEOUT_ERR=1.
